pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Detects load-use hazards between ID and EX, and handles EX-stage control-flow redirects.
- Sequences multi-cycle data-memory accesses through a req/ack wait FSM with timeout.
- Drives the pause/flush/hold controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating stall and flush counters.

Parameters:
- TIMEOUT, 16: max cycles in M_WAIT before error; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  EX destination register
- ex_is_load  in  1  EX instruction selects memory-out writeback
- ex_writeReg  in  1  EX instruction writes the register file
- ex_redirect  in  1  EX resolved a taken branch or jump
- mem_valid  in  1  MEM stage holds a load/store
- mem_ack  in  1  data memory completes the access
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF/ID keeps its contents
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_flush  out  1  ID/EX loads a bubble (drives its pause/flush input)
- id_ex_hold  out  1  ID/EX keeps its contents
- ex_mem_hold  out  1  EX/MEM keeps its contents
- mem_wb_bubble  out  1  MEM/WB loads a bubble
- mem_err  out  1  sticky memory timeout flag
- stall_cnt  out  CNT_W  cycles with pc_hold=1, saturating
- flush_cnt  out  CNT_W  redirect flushes taken, saturating

Behaviour:
- Reset: FSM=M_IDLE, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. All control outputs are forced to 0 while rst=1.
- Control outputs are combinational from inputs and FSM state (Mealy). Counters and mem_err are registered.
- Internal signals:
  - lu = ex_is_load & ex_writeReg & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - freeze = (state==M_IDLE & mem_valid & !mem_ack) | (state==M_WAIT & !mem_ack) | state==M_ERR.
- Priority, highest first:
  1. freeze: pc_hold=if_id_hold=id_ex_hold=ex_mem_hold=mem_wb_bubble=1; all flushes 0. Redirect and load-use are deferred; they are re-evaluated once the freeze lifts because EX is held.
  2. ex_redirect: if_id_flush=1, id_ex_flush=1; pc_hold=0 so PC takes the redirect target. Any concurrent lu is ignored because the ID instruction is on the wrong path.
  3. lu: pc_hold=1, if_id_hold=1, id_ex_flush=1, for exactly one cycle per hazard. The next cycle the load is in MEM and lu drops.
  4. Otherwise all control outputs are 0.
- FSM:
  - M_IDLE: mem_valid & !mem_ack goes to M_WAIT and clears the wait counter. A same-cycle ack completes with zero stall.
  - M_WAIT: the wait counter increments each cycle. mem_ack returns to M_IDLE, and freeze drops in the ack cycle itself. If the counter reaches TIMEOUT-1 without ack, go to M_ERR.
  - M_ERR: mem_err=1. The pipeline stays frozen until rst. mem_ack is ignored.
- Counters: stall_cnt increments on every cycle with pc_hold=1; flush_cnt increments on every cycle where rule 2 applies. Both saturate at 2^CNT_W-1, with no wrap.
- rst asserted mid-wait aborts the access immediately; the FSM returns to M_IDLE asynchronously.

Test Plan:
- Load-use: EX holds a load with ex_rd=5 and ex_writeReg=1; ID uses rs1=5 -> exactly one cycle of pc_hold=1, if_id_hold=1, id_ex_flush=1; stall_cnt=1. Same case with ex_rd=0 -> no stall.
- Redirect with simultaneous lu=1 -> if_id_flush=1, id_ex_flush=1, pc_hold=0; flush_cnt increments by 1.
- mem_valid=1 with ack 3 cycles later -> freeze for 3 cycles with all holds=1 and mem_wb_bubble=1; freeze drops in the ack cycle; stall_cnt=3. An ex_redirect present during the freeze produces no flush until the freeze lifts.
- mem_valid with no ack, TIMEOUT=4 -> M_ERR entered after 4 wait cycles; mem_err=1 and the freeze persists; asserting rst clears all outputs and mem_err.
- Force stall_cnt to 2^CNT_W-2, then hold the stall 3 more cycles -> stall_cnt stays at 2^CNT_W-1 and does not wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/redirect hazard control, memory wait FSM with timeout, stall/flush counters
// Inputs : clk, rst (async, active-high), ID source regs/uses, EX dest/load/write/redirect, mem_valid/mem_ack
// Outputs: pc_hold, if_id_hold/flush, id_ex_flush/hold, ex_mem_hold, mem_wb_bubble (Mealy, 0 in reset),
//          mem_err (sticky timeout), stall_cnt/flush_cnt (saturating)
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_writeReg,
    input  logic             ex_redirect,
    input  logic             mem_valid,
    input  logic             mem_ack,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {M_IDLE, M_WAIT, M_ERR} state_t;
    state_t state, state_n;
    logic [7:0] wait_cnt, wait_cnt_n;
    logic lu, freeze, act, redir;
    assign lu = ex_is_load & ex_writeReg & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign freeze = (state == M_IDLE & mem_valid & !mem_ack) | (state == M_WAIT & !mem_ack) | (state == M_ERR);
    assign act = !rst;
    // a redirect outranks load-use: the ID instruction is on the wrong path
    assign redir = act & !freeze & ex_redirect;
    assign pc_hold = act & (freeze | (!ex_redirect & lu));
    assign if_id_hold = pc_hold;
    assign if_id_flush = redir;
    assign id_ex_flush = act & !freeze & (ex_redirect | lu);
    assign id_ex_hold = act & freeze;
    assign ex_mem_hold = act & freeze;
    assign mem_wb_bubble = act & freeze;
    always_comb begin
        state_n = state;
        wait_cnt_n = wait_cnt;
        case (state)
            M_IDLE: begin
                state_n = (mem_valid & !mem_ack) ? M_WAIT : M_IDLE;
                wait_cnt_n = '0;
            end
            M_WAIT: begin
                state_n = mem_ack ? M_IDLE : (wait_cnt == 8'(TIMEOUT - 1)) ? M_ERR : M_WAIT;
                wait_cnt_n = wait_cnt + 8'd1;
            end
            default: state_n = M_ERR;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= M_IDLE;
            wait_cnt <= '0;
            mem_err <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            wait_cnt <= wait_cnt_n;
            mem_err <= mem_err | (state_n == M_ERR);
            stall_cnt <= stall_cnt + CNT_W'(pc_hold & (stall_cnt != '1));
            flush_cnt <= flush_cnt + CNT_W'(redir & (flush_cnt != '1));
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int SAT = 15;
    logic clk = 0, rst = 1;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_writeReg = 0, ex_redirect = 0;
    logic mem_valid = 0, mem_ack = 0;
    logic pc_hold, if_id_hold, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    int n_cmp = 0, n_bad = 0;
    bit m_pend, m_err;
    int m_waited, m_stall, m_flush;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_writeReg(ex_writeReg),
        .ex_redirect(ex_redirect), .mem_valid(mem_valid), .mem_ack(mem_ack), .pc_hold(pc_hold),
        .if_id_hold(if_id_hold), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic set_in(input int rs1, rs2, u1, u2, rd, ld, wr, rdr, mv, ack);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1[0]; id_use_rs2 = u2[0];
        ex_rd = 5'(rd); ex_is_load = ld[0]; ex_writeReg = wr[0]; ex_redirect = rdr[0];
        mem_valid = mv[0]; mem_ack = ack[0];
    endtask

    // Check outputs mid-cycle against the model, then advance the model across the coming edge.
    task automatic step();
        bit frz, hz, hold, fl;
        int exp_ctrl;
        #1;
        if (rst) begin
            m_pend = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        end
        frz = m_err || (m_pend ? !mem_ack : (mem_valid && !mem_ack));
        hz = ex_is_load && ex_writeReg && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        // order: pc_hold, if_id_hold, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold, mem_wb_bubble
        exp_ctrl = rst ? 0 : frz ? 7'b1100111 : ex_redirect ? 7'b0011000 : hz ? 7'b1101000 : 0;
        chk("ctrl", {25'd0, pc_hold, if_id_hold, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold, mem_wb_bubble}, exp_ctrl);
        chk("mem_err", {31'd0, mem_err}, int'(m_err));
        chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
        chk("flush_cnt", {28'd0, flush_cnt}, m_flush);
        if (!rst) begin
            hold = exp_ctrl[6];
            fl = exp_ctrl[4];
            if (hold && m_stall < SAT) m_stall++;
            if (fl && m_flush < SAT) m_flush++;
            if (!m_err) begin
                if (m_pend) begin
                    if (mem_ack) m_pend = 0;
                    else if (m_waited + 1 == TO) begin m_err = 1; m_pend = 0; end
                    else m_waited++;
                end else if (mem_valid && !mem_ack) begin
                    m_pend = 1; m_waited = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst = 1;
        step(); step();
        rst = 0;
        // load-use on rs1=5: one stall cycle, then the load has moved on
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0); step();
        chk("lu_stall_cnt", {28'd0, stall_cnt}, 1);
        set_in(5, 0, 1, 0, 9, 0, 1, 0, 1, 1); step();
        // load to x0 is never a hazard
        set_in(0, 0, 1, 0, 0, 1, 1, 0, 0, 0); step();
        chk("x0_no_stall", {28'd0, stall_cnt}, 1);
        // redirect beats a concurrent load-use
        set_in(5, 0, 1, 0, 5, 1, 1, 1, 0, 0); step();
        chk("redir_flush_cnt", {28'd0, flush_cnt}, 1);
        chk("redir_no_stall", {28'd0, stall_cnt}, 1);
        // 3-cycle memory wait with a redirect waiting behind it
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (3) step();
        chk("frz_no_flush", {28'd0, flush_cnt}, 1);
        chk("frz_stall_cnt", {28'd0, stall_cnt}, 4);
        mem_ack = 1; #1;
        chk("ack_cycle_pc", {31'd0, pc_hold}, 0);
        chk("ack_cycle_flush", {31'd0, if_id_flush}, 1);
        step();
        chk("post_ack_flush_cnt", {28'd0, flush_cnt}, 2);
        // timeout: idle cycle plus TO wait cycles, then sticky error
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) step();
        chk("pre_err", {31'd0, mem_err}, 0);
        step();
        chk("err_set", {31'd0, mem_err}, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) step();
        chk("stall_14", {28'd0, stall_cnt}, SAT - 1);
        repeat (3) step();
        chk("stall_sat", {28'd0, stall_cnt}, SAT);
        chk("err_frozen", {31'd0, pc_hold}, 1);
        rst = 1; #1;
        chk("rst_err", {31'd0, mem_err}, 0);
        chk("rst_pc", {31'd0, pc_hold}, 0);
        step();
        chk("rst_stall", {28'd0, stall_cnt}, 0);
        rst = 0;
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 5) == 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
                   $urandom_range(0, 1));
            rst = ($urandom_range(0, 39) == 0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
